// File: rtl/pkt_stream_rx_buffer.sv
// Packet receive buffer: collects WIN_BYTES-wide windows into a single packet store, then drains it one byte at a time.
// Optional statistics counters are built only when PKT_RX_STATS_EN is defined.
module pkt_stream_rx_buffer #(
    parameter int WIN_BYTES     = 16,
    parameter int MAX_PKT_BYTES = 1518
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIN_BYTES*8-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    input  logic                   out_ready,
    output logic [15:0]            out_len,
    output logic [15:0]            stat_pkts,
    output logic [15:0]            stat_drops,
    output logic [15:0]            stat_proto_err
);

    localparam int NWIN = MAX_PKT_BYTES / WIN_BYTES;
    localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int CW   = $clog2(NWIN + 1);
    localparam int BW   = (WIN_BYTES > 1) ? $clog2(WIN_BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                 state_r, state_s;
    logic [CW-1:0]          wr_cnt_r, wr_cnt_s;
    logic                   store_en_s;
    logic [WW-1:0]          store_idx_s;
    logic                   drain_start_s;
    logic [15:0]            len_s;
    logic                   in_xfer_s, out_xfer_s;

    logic [WIN_BYTES*8-1:0] mem [NWIN];

    logic                   in_ready_r;
    logic [7:0]             out_data_r;
    logic                   out_valid_r, out_sop_r, out_eop_r;
    logic [15:0]            out_len_r;
    logic [WW-1:0]          rd_word_r, rd_word_nxt_s;
    logic [BW-1:0]          rd_byte_r, rd_byte_nxt_s;
    logic [15:0]            rd_cnt_r;
    logic                   rd_last_byte_s;
    logic [WIN_BYTES*8-1:0] rd_win_s;
    logic [7:0]             nxt_byte_s;
    logic [7:0]             first_byte_s;

    assign in_xfer_s  = in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && out_ready;

    // Next-state logic and window store decisions
    always_comb begin
        state_s       = state_r;
        wr_cnt_s      = wr_cnt_r;
        store_en_s    = 1'b0;
        store_idx_s   = {WW{1'b0}};
        drain_start_s = 1'b0;
        case (state_r)
            IDLE, COLLECT: begin
                if (in_xfer_s) begin
                    if (in_sop) begin
                        // a fresh sop always restarts at window 0, abandoning any partial packet
                        store_en_s  = 1'b1;
                        store_idx_s = {WW{1'b0}};
                        wr_cnt_s    = CW'(1'b1);
                        if (in_eop) begin
                            state_s       = DRAIN;
                            drain_start_s = 1'b1;
                        end else begin
                            state_s = COLLECT;
                        end
                    end else if (state_r == IDLE) begin
                        state_s = IDLE;
                    end else if (wr_cnt_r == CW'(NWIN)) begin
                        state_s  = in_eop ? IDLE : DROP;
                        wr_cnt_s = {CW{1'b0}};
                    end else begin
                        store_en_s  = 1'b1;
                        store_idx_s = WW'(wr_cnt_r);
                        wr_cnt_s    = wr_cnt_r + CW'(1'b1);
                        if (in_eop) begin
                            state_s       = DRAIN;
                            drain_start_s = 1'b1;
                        end else begin
                            state_s = COLLECT;
                        end
                    end
                end else begin
                    state_s = state_r;
                end
            end
            DROP: begin
                if (in_xfer_s && in_eop) begin
                    state_s = IDLE;
                end else begin
                    state_s = DROP;
                end
            end
            DRAIN: begin
                if (out_xfer_s && out_eop_r) begin
                    state_s  = IDLE;
                    wr_cnt_s = {CW{1'b0}};
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s  = IDLE;
                wr_cnt_s = {CW{1'b0}};
            end
        endcase
    end

    assign len_s = 16'(32'(wr_cnt_s) * 32'(WIN_BYTES));

    // Read-side address stepping and byte selection for the drain
    always_comb begin
        rd_last_byte_s = (rd_byte_r == BW'(WIN_BYTES - 1));
        if (rd_last_byte_s) begin
            rd_byte_nxt_s = {BW{1'b0}};
            rd_word_nxt_s = rd_word_r + WW'(1'b1);
        end else begin
            rd_byte_nxt_s = rd_byte_r + BW'(1'b1);
            rd_word_nxt_s = rd_word_r;
        end
        rd_win_s   = mem[rd_word_nxt_s];
        nxt_byte_s = rd_win_s[{rd_byte_nxt_s, 3'b000} +: 8];
        // a single-window packet is still in flight on in_data when the drain starts
        if (store_idx_s == {WW{1'b0}}) begin
            first_byte_s = in_data[7:0];
        end else begin
            first_byte_s = mem[{WW{1'b0}}][7:0];
        end
    end

    // Packet store; contents need no reset
    always_ff @(posedge clk) begin
        if (store_en_s) begin
            mem[store_idx_s] <= in_data;
        end
    end

    // FSM state, handshake and drained-byte registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            wr_cnt_r    <= {CW{1'b0}};
            in_ready_r  <= 1'b0;
            out_data_r  <= 8'd0;
            out_valid_r <= 1'b0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_len_r   <= 16'd0;
            rd_word_r   <= {WW{1'b0}};
            rd_byte_r   <= {BW{1'b0}};
            rd_cnt_r    <= 16'd0;
        end else begin
            state_r    <= state_s;
            wr_cnt_r   <= wr_cnt_s;
            in_ready_r <= (state_s != DRAIN);
            if (drain_start_s) begin
                out_len_r   <= len_s;
                out_valid_r <= 1'b1;
                out_sop_r   <= 1'b1;
                out_eop_r   <= (len_s == 16'd1);
                out_data_r  <= first_byte_s;
                rd_word_r   <= {WW{1'b0}};
                rd_byte_r   <= {BW{1'b0}};
                rd_cnt_r    <= 16'd0;
            end else if (out_xfer_s) begin
                if (out_eop_r) begin
                    out_valid_r <= 1'b0;
                    out_sop_r   <= 1'b0;
                    out_eop_r   <= 1'b0;
                end else begin
                    out_data_r <= nxt_byte_s;
                    out_sop_r  <= 1'b0;
                    out_eop_r  <= ((rd_cnt_r + 16'd2) == out_len_r);
                    rd_word_r  <= rd_word_nxt_s;
                    rd_byte_r  <= rd_byte_nxt_s;
                    rd_cnt_r   <= rd_cnt_r + 16'd1;
                end
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_sop   = out_sop_r;
    assign out_eop   = out_eop_r;
    assign out_len   = out_len_r;

`ifdef PKT_RX_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
        if (en && (val != 16'hFFFF)) begin
            return val + 16'd1;
        end else begin
            return val;
        end
    endfunction

    logic        proto_err_s, drop_s, pkt_done_s;
    logic [15:0] stat_pkts_r, stat_drops_r, stat_proto_err_r;

    assign proto_err_s = in_xfer_s && (((state_r == IDLE) && !in_sop) ||
                                       ((state_r == COLLECT) && in_sop));
    assign drop_s      = in_xfer_s && (state_r == COLLECT) && !in_sop &&
                         (wr_cnt_r == CW'(NWIN));
    assign pkt_done_s  = out_xfer_s && out_eop_r;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_pkts_r      <= 16'd0;
            stat_drops_r     <= 16'd0;
            stat_proto_err_r <= 16'd0;
        end else begin
            stat_pkts_r      <= sat_inc(stat_pkts_r, pkt_done_s);
            stat_drops_r     <= sat_inc(stat_drops_r, drop_s);
            stat_proto_err_r <= sat_inc(stat_proto_err_r, proto_err_s);
        end
    end

    assign stat_pkts      = stat_pkts_r;
    assign stat_drops     = stat_drops_r;
    assign stat_proto_err = stat_proto_err_r;
`else
    assign stat_pkts      = 16'd0;
    assign stat_drops     = 16'd0;
    assign stat_proto_err = 16'd0;
`endif

endmodule
